dsi_lane_distributor: RTL



---
 rtl/dsi_lane_distributor.sv | 131 +++++++++++++
 1 files changed

// File: rtl/dsi_lane_distributor.sv
// Re-gears 32-bit packet words into N-byte beats striped over N DSI lanes (N = 1..4), tagging each byte with the packet LP bit.
// Latency: first write the cycle after accept. Backpressure: a beat waits until all its lanes are non-full; in_ready drops above 4 held bytes.
module dsi_lane_distributor #(
  parameter int ACC_BYTES = 8
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic [1:0]  reg_lanes_number,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic [3:0]  in_strb,
  input  logic        in_lp,
  input  logic        in_last,
  output logic [35:0] lane_fifo_data,
  output logic [3:0]  lane_fifo_write,
  input  logic [3:0]  lane_fifo_full,
  output logic        busy,
  output logic        pkt_done,
  output logic        err_strb
);

  typedef struct packed {
    logic       lp;
    logic [7:0] dat;
  } lane_ent_t;

  logic [ACC_BYTES-1:0][7:0] acc, acc_shift, acc_nxt;
  logic [3:0] acc_cnt, cnt_shift, cnt_nxt;
  logic [3:0] n_act, beat_len, fire_len, strb_len, take_len;
  logic [3:0] wr_mask;
  logic [1:0] n_lat;
  logic       lp_lat, in_packet, last_pend;
  logic       beat_fire, accept, pkt_end, strb_bad;
  lane_ent_t [3:0] lane_ent;

  // A short final beat is only allowed once the packet's last word is in.
  always_comb begin
    n_act = {2'b00, n_lat} + 4'd1;
    if (acc_cnt >= n_act)
      beat_len = n_act;
    else if (last_pend)
      beat_len = acc_cnt;
    else
      beat_len = 4'd0;
    wr_mask = '0;
    for (int k = 0; k < 4; k++)
      wr_mask[k] = (k < int'(beat_len));
  end

  assign beat_fire = rst_n & (beat_len != 4'd0) & ~|(lane_fifo_full & wr_mask);
  assign fire_len  = beat_fire ? beat_len : 4'd0;

  assign strb_len = !in_strb[0] ? 4'd0 :
                    !in_strb[1] ? 4'd1 :
                    !in_strb[2] ? 4'd2 :
                    !in_strb[3] ? 4'd3 : 4'd4;

  assign in_ready = rst_n & (acc_cnt <= 4'd4) & ~last_pend;
  assign accept   = in_valid & in_ready;
  assign take_len = accept ? strb_len : 4'd0;

  assign strb_bad = !(in_strb inside {4'h0, 4'h1, 4'h3, 4'h7, 4'hF}) |
                    (~in_last & (in_strb != 4'hF) & (in_strb != 4'h0));

  assign cnt_shift = acc_cnt - fire_len;
  assign cnt_nxt   = cnt_shift + take_len;
  assign acc_shift = acc >> {fire_len, 3'b000};

  // Accepts only happen with at most 4 bytes left after the shift, so the append never overruns.
  always_comb begin
    acc_nxt = acc_shift;
    for (int j = 0; j < ACC_BYTES; j++) begin
      for (int i = 0; i < 4; i++) begin
        if ((i < int'(take_len)) && (j == int'(cnt_shift) + i))
          acc_nxt[j] = in_data[i*8 +: 8];
      end
    end
  end

  // Second term closes a packet whose last word carried no bytes into an empty accumulator.
  assign pkt_end = last_pend & ((beat_fire & (cnt_nxt == 4'd0)) | (acc_cnt == 4'd0));

  always_comb begin
    lane_ent = '0;
    for (int k = 0; k < 4; k++) begin
      if (beat_fire && wr_mask[k]) begin
        lane_ent[k].lp  = lp_lat;
        lane_ent[k].dat = acc[k];
      end
    end
  end

  assign lane_fifo_data  = lane_ent;
  assign lane_fifo_write = beat_fire ? wr_mask : 4'b0000;
  assign busy            = in_packet | (acc_cnt != 4'd0);

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      acc       <= '0;
      acc_cnt   <= '0;
      in_packet <= 1'b0;
      last_pend <= 1'b0;
      n_lat     <= '0;
      lp_lat    <= 1'b0;
      pkt_done  <= 1'b0;
      err_strb  <= 1'b0;
    end else begin
      acc      <= acc_nxt;
      acc_cnt  <= cnt_nxt;
      pkt_done <= pkt_end;
      if (accept && strb_bad)
        err_strb <= 1'b1;
      if (accept && !in_packet) begin
        n_lat  <= reg_lanes_number;
        lp_lat <= in_lp;
      end
      // accept needs ~last_pend and pkt_end needs last_pend, so they never coincide.
      if (pkt_end) begin
        in_packet <= 1'b0;
        last_pend <= 1'b0;
      end else begin
        if (accept)
          in_packet <= 1'b1;
        if (accept && in_last)
          last_pend <= 1'b1;
      end
    end
  end

endmodule
